// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD display controller: serial double-dabble conversion of an 8-bit value,
// plus a free-running scanner that multiplexes three digits onto one 7-segment bus.
module bcd_display_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bin_in,
    input  logic       bin_valid,
    output logic       bin_ready,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       conv_done,
    output logic [6:0] seg,
    output logic [2:0] dig_sel
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, state_next;
    logic          load, shift_en, publish;
    logic [7:0]    sreg;
    logic [11:0]   scratch;
    logic [11:0]   adj;
    logic [19:0]   shifted;
    logic [2:0]    count;
    logic [PW-1:0] prescale;
    logic [1:0]    scan_idx;
    logic [3:0]    cur_digit;
    logic          cur_blank;
    logic [2:0]    cur_sel;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    always_comb begin
        adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
    end

    assign shifted = {adj, sreg} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        bin_ready  = 1'b0;
        load       = 1'b0;
        shift_en   = 1'b0;
        publish    = 1'b0;
        case (state)
            IDLE: begin
                bin_ready = 1'b1;
                if (bin_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (count == 3'd7) state_next = DONE;
            end
            DONE: begin
                publish    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results are only copied out once all eight shifts are complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= '0;
            scratch   <= '0;
            count     <= '0;
            bcd_hund  <= '0;
            bcd_tens  <= '0;
            bcd_ones  <= '0;
            conv_done <= 1'b0;
        end else begin
            conv_done <= publish;
            if (load) begin
                sreg    <= bin_in;
                scratch <= '0;
                count   <= '0;
            end else if (shift_en) begin
                scratch <= shifted[19:8];
                sreg    <= shifted[7:0];
                count   <= count + 3'd1;
            end
            if (publish) begin
                bcd_hund <= scratch[11:8];
                bcd_tens <= scratch[7:4];
                bcd_ones <= scratch[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            scan_idx <= '0;
        end else if (prescale == PW'(SCAN_DIV - 1)) begin
            prescale <= '0;
            scan_idx <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    // A zero tens digit is only leading when the hundreds digit is also zero.
    always_comb begin
        cur_digit = bcd_ones;
        cur_blank = 1'b0;
        cur_sel   = 3'b001;
        case (scan_idx)
            2'd1: begin
                cur_digit = bcd_tens;
                cur_blank = BLANK_LZ && (bcd_hund == 4'd0) && (bcd_tens == 4'd0);
                cur_sel   = 3'b010;
            end
            2'd2: begin
                cur_digit = bcd_hund;
                cur_blank = BLANK_LZ && (bcd_hund == 4'd0);
                cur_sel   = 3'b100;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg     <= 7'b0000000;
            dig_sel <= 3'b001;
        end else begin
            seg     <= cur_blank ? 7'b0000000 : decode(cur_digit);
            dig_sel <= cur_sel;
        end
    end

endmodule
